// File: rtl/md5_sched_pkg.sv
// Shared types and constants for the MD5 lane scheduler.
package md5_sched_pkg;

  localparam int unsigned HASH_W = 128;
  localparam int unsigned TEXT_W = 128;

  localparam logic [7:0] DEF_FIRST_CHAR = 8'h61;
  localparam logic [7:0] DEF_LAST_CHAR  = 8'h7a;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    FOUND     = 2'd2,
    EXHAUSTED = 2'd3
  } sched_state_e;

endpackage

// File: rtl/md5_lane_pick.sv
// Find-first-set over N request bits: lowest set index plus a valid flag.
module md5_lane_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid_c,
  output logic [IW-1:0] idx_c
);

  // Scan high to low so the lowest set bit is the last to write.
  always_comb begin
    valid_c = |req;
    idx_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx_c = IW'(i);
    end
  end

endmodule

// File: rtl/md5_lane_scheduler.sv
// Dispatches first characters to idle cracker lanes and collects done/match reports.
module md5_lane_scheduler
  import md5_sched_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 4,
  parameter logic [7:0]  FIRST_CHAR = DEF_FIRST_CHAR,
  parameter logic [7:0]  LAST_CHAR  = DEF_LAST_CHAR
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [HASH_W-1:0]           target_hash,
  input  logic [NUM_LANES-1:0]        lane_done,
  input  logic [NUM_LANES-1:0]        lane_found,
  input  logic [TEXT_W*NUM_LANES-1:0] lane_plaintext,
  output logic [NUM_LANES-1:0]        lane_start,
  output logic [7:0]                  lane_first_char,
  output logic [NUM_LANES-1:0]        lane_abort,
  output logic [HASH_W-1:0]           lane_target_hash,
  output logic                        busy,
  output logic                        found,
  output logic                        not_found,
  output logic [TEXT_W-1:0]           result_plaintext,
  output logic [3:0]                  result_lane
);

  localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  sched_state_e           state;
  logic [NUM_LANES-1:0]   lane_busy;
  logic [8:0]             next_char;

  logic                   idle_valid_c;
  logic [IDX_W-1:0]       idle_idx_c;
  logic                   win_valid_c;
  logic [IDX_W-1:0]       win_idx_c;
  logic [NUM_LANES-1:0]   idle_onehot_c;
  logic [NUM_LANES-1:0]   win_onehot_c;
  logic [NUM_LANES-1:0]   busy_after_done_c;
  logic                   chars_left_c;

  md5_lane_pick #(.N(NUM_LANES), .IW(IDX_W)) u_idle_pick (
    .req     (~lane_busy),
    .valid_c (idle_valid_c),
    .idx_c   (idle_idx_c)
  );

  // Only busy lanes may report a match.
  md5_lane_pick #(.N(NUM_LANES), .IW(IDX_W)) u_win_pick (
    .req     (lane_found & lane_busy),
    .valid_c (win_valid_c),
    .idx_c   (win_idx_c)
  );

  assign idle_onehot_c     = NUM_LANES'(1) << idle_idx_c;
  assign win_onehot_c      = NUM_LANES'(1) << win_idx_c;
  assign busy_after_done_c = lane_busy & ~lane_done;
  assign chars_left_c      = (next_char <= {1'b0, LAST_CHAR});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      lane_busy        <= '0;
      next_char        <= '0;
      lane_start       <= '0;
      lane_first_char  <= '0;
      lane_abort       <= '0;
      lane_target_hash <= '0;
      busy             <= 1'b0;
      found            <= 1'b0;
      not_found        <= 1'b0;
      result_plaintext <= '0;
      result_lane      <= '0;
    end else begin
      lane_start <= '0;
      lane_abort <= '0;
      case (state)
        IDLE, FOUND, EXHAUSTED: begin
          if (start) begin
            state            <= RUN;
            lane_target_hash <= target_hash;
            next_char        <= {1'b0, FIRST_CHAR};
            lane_busy        <= '0;
            busy             <= 1'b1;
            found            <= 1'b0;
            not_found        <= 1'b0;
          end
        end
        RUN: begin
          if (win_valid_c) begin
            state            <= FOUND;
            result_plaintext <= lane_plaintext[TEXT_W*int'(win_idx_c) +: TEXT_W];
            result_lane      <= 4'(win_idx_c);
            found            <= 1'b1;
            busy             <= 1'b0;
            lane_abort       <= lane_busy & ~win_onehot_c;
            lane_busy        <= '0;
          end else if (abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            lane_abort <= lane_busy;
            lane_busy  <= '0;
          end else if (idle_valid_c && chars_left_c) begin
            // Idle select uses pre-done busy bits, so a lane finishing now waits a cycle.
            lane_start      <= idle_onehot_c;
            lane_first_char <= next_char[7:0];
            lane_busy       <= busy_after_done_c | idle_onehot_c;
            next_char       <= next_char + 9'd1;
          end else begin
            lane_busy <= busy_after_done_c;
            if (!chars_left_c && (busy_after_done_c == '0)) begin
              state     <= EXHAUSTED;
              busy      <= 1'b0;
              not_found <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
